// File: rtl/gemm_stream_engine.sv
// gemm_stream_engine
//   Weight-stationary GEMM engine for a ROWS x COLS systolic array.
//   Each accepted activation vector a[ROWS] yields y[c] = sum_r a[r]*w[r][c],
//   delivered through a first-word-fall-through result FIFO. A job covers
//   exactly `len` vectors and ends with a one-cycle `done` pulse.
//
//   Optional feature macro: GEMM_RELU_EN (clamp negative results to zero).
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   w_valid/w_ready      weight load handshake (ready only in IDLE)
//   w_data               weight matrix w[r][c]
//   start, len           job start and vector count (sampled in IDLE)
//   busy, done           job status, one-cycle completion pulse
//   in_valid/in_ready    activation vector handshake
//   in_data              activation vector a[r]
//   out_valid/out_ready  result handshake (FIFO not empty)
//   out_data, out_last   result vector y[c], final-result marker
module gemm_stream_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_data,
  input  logic                                  start,
  input  logic [LEN_W-1:0]                      len,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]           in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [COLS-1:0][ACC_W-1:0]            out_data,
  output logic                                  out_last
);

  localparam int LAT   = ROWS + COLS;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int INF_W = $clog2(LAT + 1);
  localparam int ENT_W = COLS * ACC_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  state_t                                state;
  logic [LEN_W-1:0]                      remaining;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] weight;
  logic [LAT-1:0]                        tag_valid;
  logic [LAT-1:0]                        tag_last;
  logic [INF_W-1:0]                      inflight;
  logic [CNT_W-1:0]                      fifo_count;
  logic [PTR_W-1:0]                      wr_ptr;
  logic [PTR_W-1:0]                      rd_ptr;
  logic [ENT_W-1:0]                      fifo_mem [FIFO_DEPTH];
  logic                                  accept;
  logic                                  last_accept;
  logic                                  push;
  logic                                  pop;
  logic [31:0]                           credit;

  logic signed [DATA_W-1:0]   a_gate  [ROWS];
  logic signed [DATA_W-1:0]   a_skew  [ROWS];
  logic signed [DATA_W-1:0]   a_pe    [ROWS][COLS];
  logic signed [ACC_W-1:0]    psum    [ROWS][COLS];
  logic signed [ACC_W-1:0]    col_out [COLS];
  logic [COLS-1:0][ACC_W-1:0] res_data;

  // Credits count both buffered and in-flight results, so the pipeline
  // never needs to stall: every accepted vector already owns a FIFO slot.
  assign credit      = 32'(fifo_count) + 32'(inflight);
  assign in_ready    = (state == STREAM) && (credit < 32'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (remaining == LEN_W'(1));
  assign push        = tag_valid[LAT-1];
  assign pop         = out_valid && out_ready;
  assign w_ready     = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= STREAM;
              remaining <= len;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (last_accept) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_count == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      weight <= '0;
    end else if (w_valid && w_ready) begin
      weight <= w_data;
    end
  end

  // Occupancy tags travel alongside the data; tag_last marks the job's final vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_valid <= '0;
      tag_last  <= '0;
      inflight  <= '0;
    end else begin
      tag_valid <= {tag_valid[LAT-2:0], accept};
      tag_last  <= {tag_last[LAT-2:0], last_accept};
      inflight  <= inflight + INF_W'(accept) - INF_W'(push);
    end
  end

  // Input skew: row gi enters the array gi cycles late. Bubbles carry zeros.
  genvar gi, gj;
  for (gi = 0; gi < ROWS; gi++) begin : g_skew
    assign a_gate[gi] = accept ? $signed(in_data[gi]) : '0;
    if (gi == 0) begin : g_direct
      assign a_skew[gi] = a_gate[gi];
    end else begin : g_delay
      logic signed [DATA_W-1:0] pipe [gi];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < gi; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= a_gate[gi];
          for (int k = 1; k < gi; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign a_skew[gi] = pipe[gi-1];
    end
  end

  // PE array: activations flow right, partial sums flow down.
  for (gi = 0; gi < ROWS; gi++) begin : g_row
    for (gj = 0; gj < COLS; gj++) begin : g_col
      logic signed [DATA_W-1:0]   a_in;
      logic signed [ACC_W-1:0]    p_in;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [DATA_W-1:0]   a_q;
      logic signed [ACC_W-1:0]    p_q;
      if (gj == 0) begin : g_a_edge
        assign a_in = a_skew[gi];
      end else begin : g_a_chain
        assign a_in = a_pe[gi][gj-1];
      end
      if (gi == 0) begin : g_p_edge
        assign p_in = '0;
      end else begin : g_p_chain
        assign p_in = psum[gi-1][gj];
      end
      assign prod = a_in * $signed(weight[gi][gj]);
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_q <= '0;
          p_q <= '0;
        end else begin
          a_q <= a_in;
          p_q <= p_in + ACC_W'(prod);
        end
      end
      assign a_pe[gi][gj] = a_q;
      assign psum[gi][gj] = p_q;
    end
  end

  // Output deskew: column gj waits COLS-1-gj cycles so all columns align.
  for (gj = 0; gj < COLS; gj++) begin : g_deskew
    localparam int D = COLS - 1 - gj;
    if (D == 0) begin : g_direct
      assign col_out[gj] = psum[ROWS-1][gj];
    end else begin : g_delay
      logic signed [ACC_W-1:0] pipe [D];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < D; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= psum[ROWS-1][gj];
          for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign col_out[gj] = pipe[D-1];
    end
  end

  // Result register completes the ROWS+COLS latency and hosts the optional clamp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_data <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
`ifdef GEMM_RELU_EN
        res_data[c] <= col_out[c][ACC_W-1] ? '0 : col_out[c];
`else
        res_data[c] <= col_out[c];
`endif
      end
    end
  end

  // Result FIFO storage; contents need no reset because reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tag_last[LAT-1], res_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr][ENT_W-2:0] : '0;
  assign out_last  = out_valid && fifo_mem[rd_ptr][ENT_W-1];

endmodule
